// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with N_IN signed spike synapses.
//
// Each cycle it counts the excitatory (+1) and inhibitory (-1) pulses, adds
// their net to a saturating membrane potential, and fires a one-cycle signed
// spike when the potential would exceed THRESHOLD. After a fire the potential
// is cleared and the neuron ignores input for REFRACT cycles.
//
// Compile-time option:
//   LIF_NEURON_LEAK_EN  when defined, a free-running counter subtracts 1 from
//                       the potential every LEAK_PERIOD cycles (dropped while
//                       refractory). When undefined the neuron does not leak.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   spike_in   per-channel spike pulse [N_IN]
//   sign_in    per-channel polarity, 1 = excitatory, 0 = inhibitory [N_IN]
//   weight     polarity reported on sign_out when firing
//   spike_out  registered one-cycle fire pulse
//   sign_out   registered polarity of the fire pulse, 0 when not firing
//   potential  registered membrane potential [CNT_W]

module lif_neuron #(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned THRESHOLD   = 2,
  parameter int unsigned REFRACT     = 2,
  parameter int unsigned LEAK_PERIOD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   spike_in,
  input  logic [N_IN-1:0]   sign_in,
  input  logic              weight,
  output logic              spike_out,
  output logic              sign_out,
  output logic [CNT_W-1:0]  potential
);

  // Pulse-count width, signed sum width and refractory counter width.
  localparam int unsigned PC_W  = $clog2(N_IN + 1);
  localparam int unsigned SUM_W = CNT_W + PC_W + 1;
  localparam int unsigned RC_W  = (REFRACT > 1) ? $clog2(REFRACT) : 1;

  localparam logic [CNT_W-1:0]        POT_MAX = '1;
  localparam logic signed [SUM_W-1:0] SUM_MAX = $signed(SUM_W'(POT_MAX));

  localparam logic [0:0] ST_INTEGRATE  = 1'b0;
  localparam logic [0:0] ST_REFRACTORY = 1'b1;

  // Elaboration-time parameter sanity checks.
  if (N_IN < 1) begin : g_chk_n_in
    $error("lif_neuron: N_IN must be at least 1");
  end
  if (THRESHOLD >= (2 ** CNT_W) - 1) begin : g_chk_threshold
    $error("lif_neuron: THRESHOLD must be below the saturated potential");
  end
  if (LEAK_PERIOD < 2) begin : g_chk_leak_period
    $error("lif_neuron: LEAK_PERIOD must be at least 2");
  end

  logic [0:0]       state_q, state_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic [CNT_W-1:0] pot_q, pot_d;
  logic             spike_q, spike_d;
  logic             sign_q, sign_d;

  logic [PC_W-1:0]         pos_cnt;
  logic [PC_W-1:0]         neg_cnt;
  logic signed [SUM_W-1:0] sum_s;
  logic [CNT_W-1:0]        pot_next;
  logic                    fire;
  logic                    leak_tick;

`ifdef LIF_NEURON_LEAK_EN
  localparam int unsigned LC_W = $clog2(LEAK_PERIOD);

  logic [LC_W-1:0] leak_cnt_q;

  // Free-running leak counter; runs in every state, the tick is only
  // consumed while integrating.
  assign leak_tick = (leak_cnt_q == LC_W'(LEAK_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leak_cnt_q <= '0;
    end else if (leak_tick) begin
      leak_cnt_q <= '0;
    end else begin
      leak_cnt_q <= leak_cnt_q + LC_W'(1);
    end
  end
`else
  assign leak_tick = 1'b0;
`endif

  // Count excitatory and inhibitory pulses separately.
  always_comb begin
    pos_cnt = '0;
    neg_cnt = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (spike_in[i]) begin
        if (sign_in[i]) begin
          pos_cnt = pos_cnt + PC_W'(1);
        end else begin
          neg_cnt = neg_cnt + PC_W'(1);
        end
      end
    end
  end

  // Net update in a wide signed sum, then clamp into [0, POT_MAX].
  always_comb begin
    sum_s = $signed(SUM_W'(pot_q))
          + $signed(SUM_W'(pos_cnt))
          - $signed(SUM_W'(neg_cnt))
          - $signed(SUM_W'(leak_tick));
    if (sum_s[SUM_W-1]) begin
      pot_next = '0;
    end else if (sum_s > SUM_MAX) begin
      pot_next = POT_MAX;
    end else begin
      pot_next = sum_s[CNT_W-1:0];
    end
    fire = (pot_next > CNT_W'(THRESHOLD));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    pot_d   = pot_q;
    spike_d = 1'b0;
    sign_d  = 1'b0;

    case (state_q)
      ST_INTEGRATE: begin
        if (fire) begin
          spike_d = 1'b1;
          sign_d  = weight;
          pot_d   = '0;
          if (REFRACT > 0) begin
            state_d = ST_REFRACTORY;
            rcnt_d  = RC_W'(REFRACT - 1);
          end
        end else begin
          pot_d = pot_next;
        end
      end

      ST_REFRACTORY: begin
        // Inputs and leak are discarded; the last count leaves on this edge.
        pot_d = '0;
        if (rcnt_q == '0) begin
          state_d = ST_INTEGRATE;
        end else begin
          rcnt_d = rcnt_q - RC_W'(1);
        end
      end

      default: begin
        state_d = ST_INTEGRATE;
        rcnt_d  = '0;
        pot_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INTEGRATE;
      rcnt_q  <= '0;
      pot_q   <= '0;
      spike_q <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      pot_q   <= pot_d;
      spike_q <= spike_d;
      sign_q  <= sign_d;
    end
  end

  assign spike_out = spike_q;
  assign sign_out  = sign_q;
  assign potential = pot_q;

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Parametrised leaky integrate-and-fire neuron, the multi-synapse successor of the single-input spiking neuron. It accepts N_IN signed spike channels per cycle and integrates their net count into a saturating membrane potential. When the potential exceeds THRESHOLD it emits a one-cycle signed output spike, clears, and enters a programmable refractory period. An optional periodic leak can be compiled in; instances chain output-to-input to build SNN layers.

## Interface
- N_IN, 4, number of input synapse channels (≥1)
- CNT_W, 4, membrane potential width in bits
- THRESHOLD, 2, fire when next potential > THRESHOLD; must be < 2^CNT_W−1
- REFRACT, 2, refractory length in cycles (0 = none)
- LEAK_PERIOD, 8, cycles between leak decrements (≥2; used only with LEAK_EN)

- clk  input  1  clock; all flops update on rising edge
- rst  input  1  asynchronous reset, active-high
- spike_in  input  N_IN  per-channel spike pulse, sampled each rising edge
- sign_in  input  N_IN  per-channel polarity: 1 = excitatory (+1), 0 = inhibitory (−1); ignored where spike_in=0
- weight  input  1  output polarity driven on sign_out when firing
- spike_out  output  1  registered one-cycle fire pulse
- sign_out  output  1  registered polarity of the fire pulse; 0 when spike_out=0
- potential  output  CNT_W  registered membrane potential (debug/observe)

## Operation
- States: INTEGRATE, REFRACTORY. Reset → INTEGRATE.
- Per cycle: P = popcount(spike_in & sign_in), N = popcount(spike_in & ~sign_in); widths $clog2(N_IN+1).
- L = 1 on a leak tick (LEAK_EN only), else 0.
- next = pot + P − N − L, computed signed at CNT_W+$clog2(N_IN+1)+1 bits; clamped to [0, 2^CNT_W−1].
- INTEGRATE, next > THRESHOLD: spike_out←1, sign_out←weight, pot←0; REFRACT>0 → REFRACTORY with rcnt←REFRACT−1, else stay INTEGRATE.
- INTEGRATE, otherwise: pot←next, spike_out←0, sign_out←0.
- REFRACTORY: spike_in discarded, pot held at 0, no leak; rcnt decrements; at rcnt=0 → INTEGRATE on that edge.
- Simultaneous excitatory/inhibitory pulses net within the cycle; leak and inputs in the same cycle combine in one update.
- Upper saturation: pot never wraps; it clamps at 2^CNT_W−1 (then fires, since THRESHOLD is below max).
- Lower saturation: pot never goes below 0.

## Timing
- Reset values: spike_out=0, sign_out=0, potential=0, state=INTEGRATE, rcnt=0, leak counter=0.
- Input-to-spike latency: 1 cycle. Inputs sampled at edge k cause spike_out=1 for the cycle following edge k.
- spike_out is high for exactly one cycle per fire; back-to-back fires are possible only with REFRACT=0.
- Refractory window: exactly REFRACT edges after the fire edge ignore inputs. The edge REFRACT+1 after the fire samples inputs normally.
- Leak counter free-runs 0..LEAK_PERIOD−1 in every state. A tick is the edge where it equals LEAK_PERIOD−1; ticks during REFRACTORY are dropped.
- rst asserted at any time, including mid-refractory or with spike_out high, forces all reset values immediately. Operation resumes at the first rising edge after deassertion.

## Configuration
- LIF_NEURON_LEAK_EN defined: leak counter is instantiated and L applies as above.
- LIF_NEURON_LEAK_EN undefined: no leak counter, L≡0 (pure integrate-and-fire); LEAK_PERIOD unused.

## Test plan
Defaults unless stated; weight=1.
- Reset: rst=1 with arbitrary inputs → spike_out=0, sign_out=0, potential=0. After release, idle inputs → potential stays 0.
- Integrate/fire: channel 0 excitatory for 3 consecutive cycles → potential 1, 2, then spike_out=1 with sign_out=1 on the 3rd update and potential=0. Repeat with weight=0 → sign_out=0.
- Netting/floor:
  - potential 0, one cycle of 4 inhibitory pulses → potential stays 0.
  - Next cycle: 3 excitatory + 1 inhibitory → potential 2.
- Refractory: fire, then all 4 channels excitatory every cycle → potential stays 0 for 2 cycles. The next sample gives next=4 → spike_out=1 again. With REFRACT=0 → fires every cycle.
- Leak (LEAK_EN defined, LEAK_PERIOD=8): potential 2, no input → becomes 1 on the next tick and 0 on the following tick, then holds at 0. Build without the macro → potential holds 2 indefinitely.
- Async reset mid-refractory: assert rst between clock edges one cycle after a fire → outputs clear without waiting for a clock. After release, 3 excitatory pulses → fire on the 3rd update.
